// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC source select encoding.
package pc_pkg;

  localparam int unsigned PC_SRC_W = 3;

  typedef enum logic [PC_SRC_W-1:0] {
    PC_SEQ    = 3'd0,
    PC_TARGET = 3'd1,
    PC_JALR   = 3'd2,
    PC_TRAP   = 3'd3,
    PC_RET    = 3'd4
  } pc_src_t;

endpackage

// File: rtl/pc_unit_instret_counter.sv
// Retired-instruction counter: increments on inc, synchronous active-low clear, silent wrap.
module instret_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the multicycle core: next-PC select, alignment guard,
// in-flight/exception PC capture and retired-instruction count.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter int unsigned      CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write_i,
  input  pc_src_t           pc_src_i,
  input  logic [XLEN-1:0]   target_i,
  input  logic              ir_write_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc_plus_o,
  output logic [XLEN-1:0]   pc_old_o,
  output logic [XLEN-1:0]   epc_o,
  output logic              misalign_o,
  output logic [XLEN-1:0]   bad_addr_o,
  output logic [CNT_W-1:0]  instret_o
);

  localparam int unsigned ALIGN_W = $clog2(INSTR_BYTES);

  if (INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_instr_bytes
    $error("pc_unit: INSTR_BYTES must be 2 or 4");
  end
  if (TRAP_VECTOR[ALIGN_W-1:0] != '0) begin : g_bad_trap_vector
    $error("pc_unit: TRAP_VECTOR must be INSTR_BYTES-aligned");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_old_q, pc_old_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pc_plus_c;
  logic [XLEN-1:0] nxt_c;
  logic            nxt_misaligned_c;
  logic            inc_c;

  assign pc_plus_c = pc_q + XLEN'(INSTR_BYTES);

  // Next-PC select; unused codes fall back to sequential.
  always_comb begin
    nxt_c = pc_plus_c;
    case (pc_src_i)
      PC_TARGET: nxt_c = target_i;
      PC_JALR:   nxt_c = target_i & ~XLEN'(1);
      PC_TRAP:   nxt_c = TRAP_VECTOR;
      PC_RET:    nxt_c = epc_q;
      default:   nxt_c = pc_plus_c;
    endcase
  end

  assign nxt_misaligned_c = (nxt_c[ALIGN_W-1:0] != '0);

  // Register next-state: a misaligned commit leaves pc/epc/instret untouched.
  always_comb begin
    pc_d       = pc_q;
    pc_old_d   = pc_old_q;
    epc_d      = epc_q;
    bad_addr_d = bad_addr_q;
    misalign_d = 1'b0;
    inc_c      = 1'b0;
    if (ir_write_i) begin
      pc_old_d = pc_q;
    end
    if (pc_write_i) begin
      if (nxt_misaligned_c) begin
        misalign_d = 1'b1;
        bad_addr_d = nxt_c;
      end else begin
        pc_d = nxt_c;
        if (pc_src_i == PC_TRAP) begin
          epc_d = pc_old_q;
        end else begin
          inc_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      pc_old_q   <= RESET_VECTOR;
      epc_q      <= '0;
      bad_addr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_old_q   <= pc_old_d;
      epc_q      <= epc_d;
      bad_addr_q <= bad_addr_d;
      misalign_q <= misalign_d;
    end
  end

  instret_counter #(
    .CNT_W (CNT_W)
  ) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_c),
    .cnt   (instret_o)
  );

  assign pc_o       = pc_q;
  assign pc_plus_o  = pc_plus_c;
  assign pc_old_o   = pc_old_q;
  assign epc_o      = epc_q;
  assign misalign_o = misalign_q;
  assign bad_addr_o = bad_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random commits against a behavioural model.
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  pc_src_t     pc_src;
  logic [31:0] target;
  logic        ir_write;

  logic [31:0] pc, pc_plus, pc_old, epc, bad_addr, instret;
  logic        misalign;
  logic [31:0] s_pc, s_pc_plus, s_pc_old, s_epc, s_bad;
  logic        s_mis;
  logic [3:0]  s_instret;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [31:0] m_pc, m_old, m_epc, m_bad;
  logic        m_mis;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_write_i(pc_write), .pc_src_i(pc_src),
    .target_i(target), .ir_write_i(ir_write),
    .pc_o(pc), .pc_plus_o(pc_plus), .pc_old_o(pc_old), .epc_o(epc),
    .misalign_o(misalign), .bad_addr_o(bad_addr), .instret_o(instret)
  );

  pc_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .pc_write_i(pc_write), .pc_src_i(pc_src),
    .target_i(target), .ir_write_i(ir_write),
    .pc_o(s_pc), .pc_plus_o(s_pc_plus), .pc_old_o(s_pc_old), .epc_o(s_epc),
    .misalign_o(s_mis), .bad_addr_o(s_bad), .instret_o(s_instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model advances one clock edge from the spec's rules.
  task automatic model_edge(input logic r, input logic w, input int s,
                            input logic [31:0] t, input logic irw);
    logic [31:0] nxt, nold;
    if (!r) begin
      m_pc = 0; m_old = 0; m_epc = 0; m_bad = 0; m_mis = 0; m_cnt = 0;
      return;
    end
    nold  = irw ? m_pc : m_old;
    m_mis = 1'b0;
    if (w) begin
      case (s)
        1:       nxt = t;
        2:       nxt = {t[31:1], 1'b0};
        3:       nxt = 32'h100;
        4:       nxt = m_epc;
        default: nxt = m_pc + 32'd4;
      endcase
      if ((nxt % 4) != 0) begin
        m_mis = 1'b1;
        m_bad = nxt;
      end else begin
        if (s == 3) m_epc = m_old;
        else        m_cnt++;
        m_pc = nxt;
      end
    end
    m_old = nold;
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_plus", pc_plus, m_pc + 32'd4);
    check("pc_old", pc_old, m_old);
    check("epc", epc, m_epc);
    check("misalign", 32'(misalign), 32'(m_mis));
    check("bad_addr", bad_addr, m_bad);
    check("instret", instret, m_cnt);
    check("instret4", 32'(s_instret), m_cnt % 16);
  endtask

  task automatic step(input logic r, input logic w, input int s,
                      input logic [31:0] t, input logic irw);
    rst_n = r; pc_write = w; pc_src = pc_src_t'(3'(s)); target = t; ir_write = irw;
    @(posedge clk);
    model_edge(r, w, s, t, irw);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b0; pc_src = PC_SEQ; target = '0; ir_write = 1'b0;
    m_pc = 0; m_old = 0; m_epc = 0; m_bad = 0; m_mis = 0; m_cnt = 0;

    // Reset then idle
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

    // Sequential commits
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0);
      check("seq_pc", pc, 32'(4 * (i + 1)));
    end
    check("seq_instret", instret, 32'd4);

    // TARGET / JALR (pc is 0x10 here)
    step(1, 1, 1, 32'h40, 0);
    check("target_pc", pc, 32'h40);
    step(1, 1, 2, 32'h81, 0);
    check("jalr_pc", pc, 32'h80);

    // Misaligned target rejected, then pulse drops
    step(1, 1, 1, 32'h42, 0);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_bad", bad_addr, 32'h42);
    check("mis_pc", pc, 32'h80);
    check("mis_instret", instret, 32'd6);
    step(1, 0, 0, 0, 0);
    check("mis_drop", 32'(misalign), 32'd0);

    // Trap and return
    step(1, 1, 1, 32'h20, 0);
    step(1, 0, 0, 0, 1);
    step(1, 1, 3, 0, 0);
    check("trap_pc", pc, 32'h100);
    check("trap_epc", epc, 32'h20);
    check("trap_instret", instret, 32'd7);
    step(1, 1, 4, 0, 0);
    check("ret_pc", pc, 32'h20);

    // Same-cycle fetch and commit
    step(1, 1, 1, 32'h8, 0);
    step(1, 1, 0, 0, 1);
    check("same_old", pc_old, 32'h8);
    check("same_pc", pc, 32'hC);

    // Reset beats a same-cycle trap
    step(0, 1, 3, 0, 1);
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);

    // Narrow counter wraps after 16 commits
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0);
    check("wrap4", 32'(s_instret), 32'd0);

    // PC wrap at top of address space
    step(1, 1, 1, 32'hFFFF_FFFC, 0);
    step(1, 1, 0, 0, 0);
    check("pc_wrap", pc, 32'h0);
    check("pc_wrap_mis", 32'(misalign), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, 7)), t, ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
